keypad_emu: RTL and testbench

KEYPAD_EMU -- requirements
Module: keypad_emu

---
 rtl/keypad_emu_pkg.sv | 31 +++
 rtl/keypad_emu_lfsr.sv | 30 +++
 rtl/keypad_emu.sv | 193 +++++++++++++++++++
 tb/tb_keypad_emu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_emu_pkg.sv
// Shared constants for the keypad emulator: matrix widths, state encoding,
// key-code field positions and LFSR seed/taps.
package keypad_emu_pkg;

    localparam int KEYPAD_ROW_WIDTH = 4;
    localparam int KEYPAD_COL_WIDTH = 4;

    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 mapped onto a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_BOUNCE = 3'd1,
        ST_HOLD         = 3'd2,
        ST_REL_BOUNCE   = 3'd3,
        ST_GAP          = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_emu_lfsr.sv
// 8-bit Fibonacci LFSR producing the contact chatter pattern.
// load reseeds to LFSR_SEED; en advances one step.
module keypad_emu_lfsr
    import keypad_emu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else if (load) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/keypad_emu.sv
// Keypad switch emulator: drives one key closure into a row/column scanner.
// Macro KEYPAD_EMU_BOUNCE_EN adds press/release chatter states (LFSR-driven).
//
// state         | meaning
// IDLE          | waiting for a request; req_ready high
// PRESS_BOUNCE  | contact chatters on lfsr[0] after press
// HOLD          | contact firmly closed for the latched hold time
// REL_BOUNCE    | contact chatters on lfsr[0] during release
// GAP           | contact open before the next request is taken
module keypad_emu
    import keypad_emu_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 64,
    parameter int GAP_CYCLES    = 16,
    parameter int HOLD_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KEYPAD_ROW_WIDTH-1:0] row_n,
    output logic [KEYPAD_COL_WIDTH-1:0] col_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [3:0]                  req_key,
    input  logic [HOLD_W-1:0]           req_hold,
    output logic                        busy,
    output logic                        done,
    output logic                        contact
);

    localparam int CNT_W = max3(HOLD_W, $clog2(BOUNCE_CYCLES + 1), $clog2(GAP_CYCLES + 1));
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_key;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_tc;
    logic [HOLD_W-1:0]   w_hold_src;
    logic [CNT_W-1:0]    w_hold_load;
    logic                w_contact;
    logic [1:0]          w_row;
    logic [1:0]          w_col;
    logic [KEYPAD_COL_WIDTH-1:0] w_col_n;

    assign w_accept = req_valid & r_ready;
    assign w_tc     = (r_cnt == '0);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        w_lfsr;
    logic              w_lfsr_en;
    logic              w_unused_lfsr;

    assign w_lfsr_en     = (r_state == ST_PRESS_BOUNCE) || (r_state == ST_REL_BOUNCE);
    assign w_unused_lfsr = ^w_lfsr[7:1];
    assign w_hold_src    = r_hold;

    keypad_emu_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .en   (w_lfsr_en),
        .q    (w_lfsr)
    );
`else
    assign w_hold_src = req_hold;
`endif

    // A zero hold still gives one HOLD cycle.
    assign w_hold_load = (w_hold_src == '0) ? '0 : CNT_W'(w_hold_src - HOLD_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_hold  <= '0;
`endif
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_key   <= req_key;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        r_hold  <= req_hold;
                        r_state <= ST_PRESS_BOUNCE;
                        r_cnt   <= BOUNCE_LOAD;
`else
                        r_state <= ST_HOLD;
                        r_cnt   <= w_hold_load;
`endif
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_PRESS_BOUNCE: begin
                    if (w_tc) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= w_hold_load;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
`endif
                ST_HOLD: begin
                    if (w_tc) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        r_state <= ST_REL_BOUNCE;
                        r_cnt   <= BOUNCE_LOAD;
`else
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_REL_BOUNCE: begin
                    if (w_tc) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
`endif
                ST_GAP: begin
                    if (w_tc) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_contact = 1'b0;
        case (r_state)
            ST_HOLD:         w_contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_PRESS_BOUNCE: w_contact = w_lfsr[0];
            ST_REL_BOUNCE:   w_contact = w_lfsr[0];
`endif
            default:         w_contact = 1'b0;
        endcase
    end

    assign w_row = r_key[KEY_ROW_MSB:KEY_ROW_LSB];
    assign w_col = r_key[KEY_COL_MSB:KEY_COL_LSB];

    // Only the latched row gates the column, whatever else the scanner drives.
    always_comb begin
        w_col_n = '1;
        if (w_contact && !row_n[w_row]) begin
            w_col_n[w_col] = 1'b0;
        end
    end

    assign col_n     = w_col_n;
    assign contact   = w_contact;
    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_keypad_emu.sv
// Self-checking bench for keypad_emu: per-cycle model comparison plus
// hand-computed sequence lengths and chatter patterns.
module tb_keypad_emu;

    localparam int B  = 4;
    localparam int G  = 2;
    localparam int HW = 16;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int LEN1     = 20;
    localparam int ONES1    = 15;
    localparam int LEN_REP  = 14;
    localparam int ONES_REP = 9;
    localparam int LEN_H0   = 11;
    localparam int ONES_H0  = 6;
    localparam int LEN_B2B  = 12;
    localparam int LEN_REC  = 11;
    localparam int ONES_REC = 6;
    localparam int WAIT_H   = B + 1;
`else
    localparam int LEN1     = 12;
    localparam int ONES1    = 10;
    localparam int LEN_REP  = 6;
    localparam int ONES_REP = 4;
    localparam int LEN_H0   = 3;
    localparam int ONES_H0  = 1;
    localparam int LEN_B2B  = 4;
    localparam int LEN_REC  = 3;
    localparam int ONES_REC = 1;
    localparam int WAIT_H   = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    row_n = 4'hF;
    logic [3:0]    col_n;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_key = 4'h0;
    logic [HW-1:0] req_hold = '0;
    logic          busy;
    logic          done;
    logic          contact;

    keypad_emu #(
        .BOUNCE_CYCLES (B),
        .GAP_CYCLES    (G),
        .HOLD_W        (HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_hold  (req_hold),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each accepted request becomes a queue of expected
    // contact values, one per busy cycle.
    bit         m_q[$];
    logic       m_ready = 1'b0;
    logic       m_done  = 1'b0;
    logic [3:0] m_key   = 4'h0;
    int         m_idx   = 0;
    int         m_h     = 1;
    logic       m_acc;
    logic       m_was_busy;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic build_seq(input int h);
        logic [7:0] s;
        s = 8'hA5;
        m_q.delete();
`ifdef KEYPAD_EMU_BOUNCE_EN
        for (int i = 0; i < B; i++) begin m_q.push_back(s[0]); s = lfsr_step(s); end
`endif
        for (int i = 0; i < h; i++) m_q.push_back(1'b1);
`ifdef KEYPAD_EMU_BOUNCE_EN
        for (int i = 0; i < B; i++) begin m_q.push_back(s[0]); s = lfsr_step(s); end
`endif
        for (int i = 0; i < G; i++) m_q.push_back(1'b0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ready = 1'b0;
            m_done  = 1'b0;
            m_key   = 4'h0;
            m_idx   = 0;
        end else begin
            m_acc      = m_ready && req_valid;
            m_was_busy = (m_q.size() != 0);
            if (m_was_busy) begin
                void'(m_q.pop_front());
                m_idx++;
            end
            m_done = m_was_busy && (m_q.size() == 0);
            if (m_acc) begin
                m_key = req_key;
                m_h   = (req_hold == '0) ? 1 : int'(req_hold);
                build_seq(m_h);
                m_idx = 0;
            end
            m_ready = (m_q.size() == 0);
        end
    end

    // Per-cycle compare plus run statistics for the directed checks.
    int         done_cnt  = 0;
    int         run       = 0;
    int         ones      = 0;
    int         last_run  = 0;
    int         last_ones = 0;
    int         idle_run  = 0;
    int         last_idle = 0;
    logic       prev_busy = 1'b0;
    logic       scan_on   = 1'b0;
    int         scan_hits = 0;
    logic [3:0] press_pat = 4'h0;
    logic [3:0] rel_pat   = 4'h0;
    logic       e_busy;
    logic       e_contact;
    logic [3:0] e_col;

    always @(negedge clk) begin
        e_busy    = (m_q.size() != 0);
        e_contact = e_busy ? m_q[0] : 1'b0;
        e_col     = 4'hF;
        if (e_contact && (row_n[m_key[3:2]] == 1'b0)) e_col[m_key[1:0]] = 1'b0;
        chk("busy",    busy,      e_busy);
        chk("done",    done,      m_done);
        chk("ready",   req_ready, m_ready);
        chk("contact", contact,   e_contact);
        chk("col_n",   col_n,     e_col);
        if (scan_on && col_n !== 4'hF) begin
            scan_hits++;
            chk("scan_col", {row_n, col_n}, {4'b1011, 4'b1101});
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (e_busy && m_idx < B) press_pat = {press_pat[2:0], contact};
        if (e_busy && m_idx >= B + m_h && m_idx < 2*B + m_h) rel_pat = {rel_pat[2:0], contact};
`endif
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) begin
            if (!prev_busy) last_idle = idle_run;
            idle_run = 0;
            run++;
            if (contact === 1'b1) ones++;
        end else begin
            if (prev_busy) begin
                last_run  = run;
                last_ones = ones;
                run  = 0;
                ones = 0;
            end
            idle_run++;
        end
        prev_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (scan_on) row_n = {row_n[2:0], row_n[3]};
    endtask

    task automatic run_seq(input logic [3:0] key, input logic [HW-1:0] hold,
                           input int exp_len, input int exp_ones, input string tag);
        int d0;
        int to;
        d0 = done_cnt;
        req_key   = key;
        req_hold  = hold;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_key   = ~key;
        req_hold  = 16'd3;
        to = 0;
        while (done_cnt == d0 && to < 300) begin step(); to++; end
        chk({tag, "_timeout"},      32'(to < 300), 1);
        chk({tag, "_busy_len"},     last_run,  exp_len);
        chk({tag, "_contact_ones"}, last_ones, exp_ones);
        chk({tag, "_done_pulses"},  done_cnt - d0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int to;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   req_ready, 1'b0);
        chk("rst_busy",    busy,      1'b0);
        chk("rst_done",    done,      1'b0);
        chk("rst_contact", contact,   1'b0);
        chk("rst_col",     col_n,     4'hF);
        rst = 1'b0;
        step();
        chk("ready_after_rst", req_ready, 1'b1);

        // Key 9 (row 2, col 1) under a rotating row scan.
        row_n   = 4'b1110;
        scan_on = 1'b1;
        run_seq(4'h9, 16'd10, LEN1, ONES1, "key9");
        scan_on = 1'b0;
        chk("scan_hits_seen", 32'(scan_hits > 0), 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
        chk("press_pat_1", press_pat, 4'b1010);
        chk("rel_pat_1",   rel_pat,   4'b0111);
`endif

        // Repeat request: reseeded LFSR must reproduce the chatter.
        row_n = 4'hF;
        run_seq(4'h9, 16'd4, LEN_REP, ONES_REP, "repeat");
`ifdef KEYPAD_EMU_BOUNCE_EN
        chk("press_pat_repeat", press_pat, 4'b1010);
        chk("rel_pat_repeat",   rel_pat,   4'b0111);
`endif

        // Zero hold behaves as one cycle; several rows low at once.
        row_n = 4'b0101;
        run_seq(4'h6, 16'd0, LEN_H0, ONES_H0, "hold0");

        // Back-to-back with req_valid held high.
        row_n     = 4'b1101;
        d0        = done_cnt;
        req_key   = 4'h3;
        req_hold  = 16'd2;
        req_valid = 1'b1;
        to = 0;
        while (done_cnt < d0 + 2 && to < 300) begin step(); to++; end
        req_valid = 1'b0;
        while (done_cnt < d0 + 3 && to < 300) begin step(); to++; end
        chk("b2b_timeout",  32'(to < 300), 1);
        chk("b2b_idle_gap", last_idle, 1);
        chk("b2b_busy_len", last_run, LEN_B2B);
        chk("b2b_done_cnt", done_cnt - d0, 3);

        // Reset in the middle of HOLD.
        row_n     = 4'b0111;
        req_key   = 4'hF;
        req_hold  = 16'd10;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (WAIT_H) step();
        chk("pre_rst_col",  col_n, 4'b0111);
        chk("pre_rst_busy", busy,  1'b1);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_col",     col_n,     4'hF);
        chk("midrst_contact", contact,   1'b0);
        chk("midrst_busy",    busy,      1'b0);
        chk("midrst_done",    done,      1'b0);
        chk("midrst_ready",   req_ready, 1'b0);
        step();
        step();
        rst = 1'b0;
        repeat (2*B + G + 16) step();
        chk("rst_no_done",   done_cnt - d0, 0);
        chk("ready_post_rst", req_ready, 1'b1);

        // Recovery after reset.
        row_n = 4'b1110;
        run_seq(4'h0, 16'd1, LEN_REC, ONES_REC, "recover");

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
